// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encodings, flag indices and default widths
// for one TDC channel (controller, encoders and coarse counter).
package tdc_pkg;

  localparam int FINE_W_DEF      = 5;
  localparam int COARSE_W_DEF    = 4;
  localparam int PIPE_LAT_DEF    = 2;
  localparam int TIMEOUT_CYC_DEF = 255;

  // res_flags = {timeout, overflow, underflow}
  localparam int FLAG_W  = 3;
  localparam int FLG_UDF = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_TMO = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESULT  = 3'd5,
    ST_CLEAR   = 3'd6
  } state_e;

  // counter width able to hold 0..n-1, never narrower than 1
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdc_measure_ctrl_if.sv
// tdc_measure_ctrl_if: valid/ready result port of the TDC sequencer.
// master: res_valid/res_interval/res_flags out, res_ready in; slave mirrors.
interface tdc_measure_ctrl_if
  import tdc_pkg::*;
#(
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF
) ();

  logic                       res_valid;
  logic                       res_ready;
  logic [COARSE_W+FINE_W-1:0] res_interval;
  logic [FLAG_W-1:0]          res_flags;

  modport master (
    output res_valid,
    output res_interval,
    output res_flags,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_interval,
    input  res_flags,
    output res_ready
  );

endinterface

// File: rtl/tdc_interval_calc.sv
// tdc_interval_calc: merges coarse count and fine codes into one
// interval word. Ports: coarse, bin_start, bin_stop in; interval, flags out.
module tdc_interval_calc
  import tdc_pkg::*;
#(
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF
) (
  input  logic [COARSE_W-1:0]        coarse,
  input  logic [FINE_W-1:0]          bin_start,
  input  logic [FINE_W-1:0]          bin_stop,
  output logic [COARSE_W+FINE_W-1:0] interval,
  output logic [FLAG_W-1:0]          flags
);

  localparam int W = COARSE_W + FINE_W;

  // one extra bit so a stop code larger than the start code
  // with zero coarse count shows up as a negative sum
  logic signed [W:0] sum;

  assign sum = $signed({1'b0, coarse, {FINE_W{1'b0}}})
             + $signed({{(COARSE_W+1){1'b0}}, bin_start})
             - $signed({{(COARSE_W+1){1'b0}}, bin_stop});

  always_comb begin
    interval = sum[W-1:0];
    flags    = '0;
    if (&coarse) begin
      // saturated counter: the true interval is unknown
      flags[FLG_OVF] = 1'b1;
      interval       = '1;
    end else if (sum[W]) begin
      flags[FLG_UDF] = 1'b1;
      interval       = '0;
    end
  end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl: sequencer for one TDC channel; arms the hit filters,
// tracks start/stop, waits out the encoder pipeline, emits one result.
// Ports: clk, reset_n, meas_req, cfg_cont, start_valid, stop_valid,
//   bin_start, bin_stop, coarse_cnt in; arm, clear, busy out;
//   res (tdc_measure_ctrl_if.master) carries the valid/ready result.
// Build option: TDC_CTRL_TIMEOUT_EN adds an ARMED/RUNNING timeout
//   of TIMEOUT_CYC cycles; without it the timeout flag is always 0.
module tdc_measure_ctrl
  import tdc_pkg::*;
#(
  parameter int FINE_W      = FINE_W_DEF,
  parameter int COARSE_W    = COARSE_W_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF
`ifdef TDC_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                meas_req,
  input  logic                cfg_cont,
  input  logic                start_valid,
  input  logic                stop_valid,
  input  logic [FINE_W-1:0]   bin_start,
  input  logic [FINE_W-1:0]   bin_stop,
  input  logic [COARSE_W-1:0] coarse_cnt,
  output logic                arm,
  output logic                clear,
  output logic                busy,
  tdc_measure_ctrl_if.master  res
);

  localparam int W  = COARSE_W + FINE_W;
  localparam int SW = cnt_w(PIPE_LAT);

  state_e            state;
  state_e            state_nx;
  logic [SW-1:0]     settle_cnt;
  logic              settle_done;
  logic              tmo_hit;
  logic              res_vld;
  logic [W-1:0]      calc_int;
  logic [FLAG_W-1:0] calc_flg;
  logic [W-1:0]      int_q;
  logic [FLAG_W-1:0] flg_q;

  tdc_interval_calc #(
    .FINE_W   (FINE_W),
    .COARSE_W (COARSE_W)
  ) u_calc (
    .coarse    (coarse_cnt),
    .bin_start (bin_start),
    .bin_stop  (bin_stop),
    .interval  (calc_int),
    .flags     (calc_flg)
  );

  assign settle_done = (settle_cnt == SW'(PIPE_LAT - 1));

`ifdef TDC_CTRL_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt;

  // RUNNING is only reachable from ARMED, so clearing
  // outside ARMED/RUNNING restarts the count on ARMED entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (arm) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = arm && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_q <= '0;
      flg_q <= '0;
    end else if (state == ST_CAPTURE) begin
      int_q <= calc_int;
      flg_q <= calc_flg;
    end else if (tmo_hit) begin
      int_q <= '0;
      flg_q <= FLAG_W'(1 << FLG_TMO);
    end
  end

  // timeout outranks hits so the counter never runs past its limit
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (meas_req) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        if (tmo_hit) begin
          state_nx = ST_RESULT;
        end else if (start_valid && stop_valid) begin
          state_nx = ST_SETTLE;
        end else if (start_valid) begin
          state_nx = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (tmo_hit) begin
          state_nx = ST_RESULT;
        end else if (stop_valid) begin
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_done) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nx = ST_RESULT;
      end
      ST_RESULT: begin
        if (res.res_ready) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nx = cfg_cont ? ST_ARMED : ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    arm     = 1'b0;
    clear   = 1'b0;
    busy    = 1'b1;
    res_vld = 1'b0;
    unique case (state)
      ST_IDLE:              busy    = 1'b0;
      ST_ARMED, ST_RUNNING: arm     = 1'b1;
      ST_RESULT:            res_vld = 1'b1;
      ST_CLEAR:             clear   = 1'b1;
      default: ;
    endcase
  end

  assign res.res_valid    = res_vld;
  assign res.res_interval = int_q;
  assign res.res_flags    = flg_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb_tdc_measure_ctrl: randomized self-checking bench for the TDC
// sequencer against an arithmetic interval model.
module tb_tdc_measure_ctrl;

  localparam int FW = 5;
  localparam int CW = 4;
  localparam int PL = 2;
  localparam int IW = FW + CW;
`ifdef TDC_CTRL_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b0;
  logic          meas_req    = 1'b0;
  logic          cfg_cont    = 1'b0;
  logic          start_valid = 1'b0;
  logic          stop_valid  = 1'b0;
  logic [FW-1:0] bin_start   = '0;
  logic [FW-1:0] bin_stop    = '0;
  logic [CW-1:0] coarse_cnt  = '0;
  logic          arm;
  logic          clear;
  logic          busy;

  int vecs    = 0;
  int errs    = 0;
  int n_clear = 0;

  tdc_measure_ctrl_if #(.FINE_W(FW), .COARSE_W(CW)) rif ();

  tdc_measure_ctrl #(
    .FINE_W   (FW),
    .COARSE_W (CW),
    .PIPE_LAT (PL)
`ifdef TDC_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TO)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .meas_req    (meas_req),
    .cfg_cont    (cfg_cont),
    .start_valid (start_valid),
    .stop_valid  (stop_valid),
    .bin_start   (bin_start),
    .bin_stop    (bin_stop),
    .coarse_cnt  (coarse_cnt),
    .arm         (arm),
    .clear       (clear),
    .busy        (busy),
    .res         (rif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clear === 1'b1) n_clear++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  // {flags, interval} straight from the interval rules
  function automatic logic [IW+2:0] model(input int c,
                                          input int s,
                                          input int p);
    int i;
    i = c * (1 << FW) + s - p;
    if (c == (1 << CW) - 1) return {3'b010, {IW{1'b1}}};
    if (i < 0) return {3'b001, {IW{1'b0}}};
    return {3'b000, i[IW-1:0]};
  endfunction

  task automatic apply_reset();
    reset_n       = 1'b0;
    meas_req      = 1'b0;
    cfg_cont      = 1'b0;
    start_valid   = 1'b0;
    stop_valid    = 1'b0;
    rif.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic arm_meas();
    @(negedge clk);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
  endtask

  // drives one start/stop pair from ARMED and returns the number
  // of cycles from the stop pulse until res_valid is seen
  task automatic fire(input int c, input int s, input int p,
                      input int gap, input bit same,
                      input bit noise, output int lat);
    if (noise && $urandom_range(0, 1) == 1) begin
      stop_valid = 1'b1;
      @(negedge clk);
      stop_valid = 1'b0;
    end
    coarse_cnt = CW'($urandom);
    bin_start  = FW'($urandom);
    bin_stop   = FW'($urandom);
    if (same) begin
      start_valid = 1'b1;
      stop_valid  = 1'b1;
    end else begin
      start_valid = 1'b1;
      @(negedge clk);
      for (int k = 1; k < gap; k++) begin
        start_valid = noise && ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      start_valid = 1'b0;
      stop_valid  = 1'b1;
    end
    coarse_cnt = CW'(c);
    bin_start  = FW'(s);
    bin_stop   = FW'(p);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start_valid = noise && (lat == 1);
      stop_valid  = noise && (lat == 1);
    end while (rif.res_valid !== 1'b1 && lat < 40);
    start_valid = 1'b0;
    stop_valid  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vecs++;
    if (arm !== 1'b0) begin
      errs++; $display("FAIL rst_arm: got %b want 0", arm);
    end
    vecs++;
    if (clear !== 1'b0) begin
      errs++; $display("FAIL rst_clear: got %b want 0", clear);
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    vecs++;
    if (rif.res_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid: got %b want 0", rif.res_valid);
    end
    vecs++;
    if (rif.res_interval !== '0 || rif.res_flags !== '0) begin
      errs++;
      $display("FAIL rst_data: got %0d/%b want 0/000",
               rif.res_interval, rif.res_flags);
    end
  endtask

  task automatic test_happy();
    int lat;
    int nc0;
    cfg_cont = 1'b0;
    arm_meas();
    vecs++;
    if (arm !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL hp_arm: got %b%b want 11", arm, busy);
    end
    fire(3, 20, 7, 5, 1'b0, 1'b0, lat);
    vecs++;
    if (lat !== PL + 2) begin
      errs++; $display("FAIL hp_latency: got %0d want %0d", lat, PL + 2);
    end
    vecs++;
    if (rif.res_interval !== IW'(109)) begin
      errs++;
      $display("FAIL hp_interval: got %0d want 109", rif.res_interval);
    end
    vecs++;
    if (rif.res_flags !== 3'b000) begin
      errs++; $display("FAIL hp_flags: got %b want 000", rif.res_flags);
    end
    nc0 = n_clear;
    rif.res_ready = 1'b1;
    @(negedge clk);
    rif.res_ready = 1'b0;
    vecs++;
    if (clear !== 1'b1 || rif.res_valid !== 1'b0) begin
      errs++;
      $display("FAIL hp_clear: got %b%b want 10", clear, rif.res_valid);
    end
    @(negedge clk);
    vecs++;
    if (clear !== 1'b0 || busy !== 1'b0 || arm !== 1'b0) begin
      errs++;
      $display("FAIL hp_idle: got clr%b busy%b arm%b want 000",
               clear, busy, arm);
    end
    vecs++;
    if (n_clear !== nc0 + 1) begin
      errs++;
      $display("FAIL hp_nclear: got %0d want %0d", n_clear - nc0, 1);
    end
  endtask

  task automatic test_underflow();
    int lat;
    arm_meas();
    fire(0, 4, 9, 1, 1'b1, 1'b0, lat);
    vecs++;
    if (lat !== PL + 2) begin
      errs++; $display("FAIL uf_latency: got %0d want %0d", lat, PL + 2);
    end
    vecs++;
    if (rif.res_interval !== '0 || rif.res_flags !== 3'b001) begin
      errs++;
      $display("FAIL uf_result: got %0d/%b want 0/001",
               rif.res_interval, rif.res_flags);
    end
    rif.res_ready = 1'b1;
    @(negedge clk);
    rif.res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int c;
    int s;
    int p;
    int lat;
    bit same;
    logic [IW+2:0] exp;
    for (int n = 0; n < 24; n++) begin
      if (n % 6 == 0) c = (1 << CW) - 1;
      else if (n % 6 == 1) c = 0;
      else c = $urandom_range(0, (1 << CW) - 1);
      s    = $urandom_range(0, (1 << FW) - 1);
      p    = $urandom_range(0, (1 << FW) - 1);
      same = ($urandom_range(0, 3) == 0);
      exp  = model(c, s, p);
      arm_meas();
      fire(c, s, p, $urandom_range(1, 8), same, 1'b1, lat);
      vecs++;
      if (lat !== PL + 2) begin
        errs++;
        $display("FAIL rnd_latency[%0d]: got %0d want %0d",
                 n, lat, PL + 2);
      end
      vecs++;
      if (rif.res_interval !== exp[IW-1:0]) begin
        errs++;
        $display("FAIL rnd_interval[%0d] c=%0d s=%0d p=%0d: got %0d want %0d",
                 n, c, s, p, rif.res_interval, exp[IW-1:0]);
      end
      vecs++;
      if (rif.res_flags !== exp[IW+2:IW]) begin
        errs++;
        $display("FAIL rnd_flags[%0d]: got %b want %b",
                 n, rif.res_flags, exp[IW+2:IW]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rif.res_ready = 1'b1;
      @(negedge clk);
      rif.res_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int nc0;
    logic [IW+2:0] exp;
    exp = model(9, 3, 17);
    cfg_cont = 1'b0;
    arm_meas();
    fire(9, 3, 17, 3, 1'b0, 1'b0, lat);
    nc0 = n_clear;
    for (int k = 0; k < 10; k++) begin
      start_valid = k[0];
      stop_valid  = ~k[0];
      meas_req    = (k == 5);
      bin_start   = FW'($urandom);
      bin_stop    = FW'($urandom);
      coarse_cnt  = CW'($urandom);
      @(negedge clk);
      vecs++;
      if (rif.res_valid !== 1'b1 ||
          {rif.res_flags, rif.res_interval} !== exp) begin
        errs++;
        $display("FAIL bp_hold[%0d]: got v%b %b/%0d want v1 %b/%0d",
                 k, rif.res_valid, rif.res_flags, rif.res_interval,
                 exp[IW+2:IW], exp[IW-1:0]);
      end
    end
    start_valid = 1'b0;
    stop_valid  = 1'b0;
    meas_req    = 1'b0;
    vecs++;
    if (n_clear !== nc0) begin
      errs++;
      $display("FAIL bp_early_clear: got %0d want 0", n_clear - nc0);
    end
    rif.res_ready = 1'b1;
    @(negedge clk);
    rif.res_ready = 1'b0;
    vecs++;
    if (clear !== 1'b1) begin
      errs++; $display("FAIL bp_clear: got %b want 1", clear);
    end
    repeat (4) @(negedge clk);
    vecs++;
    if (n_clear !== nc0 + 1) begin
      errs++;
      $display("FAIL bp_nclear: got %0d want 1", n_clear - nc0);
    end
    vecs++;
    if (busy !== 1'b0 || arm !== 1'b0) begin
      errs++; $display("FAIL bp_idle: got %b%b want 00", busy, arm);
    end
  endtask

  task automatic test_continuous();
    int c;
    int s;
    int p;
    int lat;
    int nc0;
    logic [IW+2:0] exp;
    nc0      = n_clear;
    cfg_cont = 1'b1;
    arm_meas();
    for (int k = 0; k < 3; k++) begin
      c   = $urandom_range(1, (1 << CW) - 2);
      s   = $urandom_range(0, (1 << FW) - 1);
      p   = $urandom_range(0, (1 << FW) - 1);
      exp = model(c, s, p);
      fire(c, s, p, $urandom_range(1, 6), 1'b0, 1'b1, lat);
      vecs++;
      if ({rif.res_flags, rif.res_interval} !== exp) begin
        errs++;
        $display("FAIL ct_result[%0d]: got %b/%0d want %b/%0d",
                 k, rif.res_flags, rif.res_interval,
                 exp[IW+2:IW], exp[IW-1:0]);
      end
      rif.res_ready = 1'b1;
      @(negedge clk);
      rif.res_ready = 1'b0;
      vecs++;
      if (clear !== 1'b1 || arm !== 1'b0) begin
        errs++;
        $display("FAIL ct_clear[%0d]: got clr%b arm%b want 10",
                 k, clear, arm);
      end
      @(negedge clk);
      vecs++;
      if (arm !== 1'b1 || clear !== 1'b0) begin
        errs++;
        $display("FAIL ct_rearm[%0d]: got arm%b clr%b want 10",
                 k, arm, clear);
      end
    end
    vecs++;
    if (n_clear !== nc0 + 3) begin
      errs++;
      $display("FAIL ct_nclear: got %0d want 3", n_clear - nc0);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
`ifdef TDC_CTRL_TIMEOUT_EN
    int cyc;
    cfg_cont = 1'b0;
    arm_meas();
    start_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start_valid = 1'b0;
    end while (rif.res_valid !== 1'b1 && cyc < 60);
    vecs++;
    if (cyc !== TO) begin
      errs++; $display("FAIL to_cycles: got %0d want %0d", cyc, TO);
    end
    vecs++;
    if (rif.res_flags !== 3'b100 || rif.res_interval !== '0) begin
      errs++;
      $display("FAIL to_result: got %b/%0d want 100/0",
               rif.res_flags, rif.res_interval);
    end
    rif.res_ready = 1'b1;
    @(negedge clk);
    rif.res_ready = 1'b0;
    @(negedge clk);
`else
    cfg_cont = 1'b0;
    arm_meas();
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (100) @(negedge clk);
    vecs++;
    if (busy !== 1'b1 || arm !== 1'b1 || rif.res_valid !== 1'b0) begin
      errs++;
      $display("FAIL to_wait: got busy%b arm%b v%b want 110",
               busy, arm, rif.res_valid);
    end
    vecs++;
    if (rif.res_flags[2] !== 1'b0) begin
      errs++;
      $display("FAIL to_flag: got %b want 0", rif.res_flags[2]);
    end
    apply_reset();
`endif
  endtask

  task automatic test_reset_mid();
    int lat;
    int nc0;
    logic [IW+2:0] exp;
    arm_meas();
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    stop_valid  = 1'b1;
    @(negedge clk);
    stop_valid = 1'b0;
    vecs++;
    if (busy !== 1'b1 || arm !== 1'b0) begin
      errs++; $display("FAIL rm_settle: got %b%b want 10", busy, arm);
    end
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if ({arm, clear, busy, rif.res_valid} !== 4'b0000 ||
        rif.res_interval !== '0 || rif.res_flags !== '0) begin
      errs++;
      $display("FAIL rm_settle_out: got %b%b%b%b %0d/%b want 0000 0/000",
               arm, clear, busy, rif.res_valid,
               rif.res_interval, rif.res_flags);
    end
    nc0 = n_clear;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    vecs++;
    if (n_clear !== nc0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rm_settle_after: got clr%0d busy%b want 0 0",
               n_clear - nc0, busy);
    end
    exp = model(5, 10, 2);
    arm_meas();
    fire(5, 10, 2, 2, 1'b0, 1'b0, lat);
    vecs++;
    if ({rif.res_flags, rif.res_interval} !== exp) begin
      errs++;
      $display("FAIL rm_result: got %b/%0d want %b/%0d",
               rif.res_flags, rif.res_interval,
               exp[IW+2:IW], exp[IW-1:0]);
    end
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if ({arm, clear, busy, rif.res_valid} !== 4'b0000 ||
        rif.res_interval !== '0 || rif.res_flags !== '0) begin
      errs++;
      $display("FAIL rm_result_out: got %b%b%b%b %0d/%b want 0000 0/000",
               arm, clear, busy, rif.res_valid,
               rif.res_interval, rif.res_flags);
    end
    nc0 = n_clear;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    vecs++;
    if (n_clear !== nc0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rm_result_after: got clr%0d busy%b want 0 0",
               n_clear - nc0, busy);
    end
  endtask

  initial begin
    rif.res_ready = 1'b0;
    test_reset();
    test_happy();
    test_underflow();
    test_random();
    test_backpressure();
    test_continuous();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
